// File: rtl/seq_controller_if.sv
// Handshake and datapath-control bundle between the instruction source and seq_controller.
interface seq_if #(
  parameter int RA_W   = 3,
  parameter int DATA_W = 10,
  parameter int ONEHOT = 0,
  parameter int CNT_W  = 8
);
  localparam int IW    = 2*RA_W + 4;
  localparam int SEL_W = (ONEHOT != 0) ? (1 << RA_W) : RA_W;

  logic              run;
  logic [IW-1:0]     instr_in;
  logic [DATA_W-1:0] imm;
  logic              imm_oe;
  logic [2:0]        alu_op;
  logic [SEL_W-1:0]  rin_sel;
  logic [SEL_W-1:0]  rout_sel;
  logic              enw;
  logic              enr;
  logic              ain;
  logic              gin;
  logic              gout;
  logic              ext;
  logic              ir_in;
  logic              done;
  logic              busy;
  logic [1:0]        step;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    output run, instr_in,
    input  imm, imm_oe, alu_op, rin_sel, rout_sel, enw, enr, ain, gin, gout,
           ext, ir_in, done, busy, step, instr_cnt
  );

  modport slave (
    input  run, instr_in,
    output imm, imm_oe, alu_op, rin_sel, rout_sel, enw, enr, ain, gin, gout,
           ext, ir_in, done, busy, step, instr_cnt
  );
endinterface

// File: rtl/seq_controller.sv
// Self-sequencing 3-step control unit: latches an instruction, steps T1..T3 and
// decodes per-step datapath strobes, counting retired instructions.
module seq_controller #(
  parameter int RA_W   = 3,
  parameter int DATA_W = 10,
  parameter int ONEHOT = 0,
  parameter int CNT_W  = 8
) (
  input  logic  clk,
  input  logic  reset,
  seq_if.slave  bus
);
  localparam int IW    = 2*RA_W + 4;
  localparam int SEL_W = (ONEHOT != 0) ? (1 << RA_W) : RA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    ir;
  logic [CNT_W-1:0] cnt;

  logic             f;
  logic [RA_W-1:0]  x;
  logic [RA_W-1:0]  y;
  logic [2:0]       fn;

  logic             ext_c, ir_in_c, enw_c, enr_c, ain_c, gin_c, gout_c;
  logic             imm_oe_c, done_c;
  logic [2:0]       alu_c;
  logic [RA_W-1:0]  rin_idx, rout_idx;

  assign f  = ir[IW-1];
  assign x  = ir[IW-2 -: RA_W];
  assign y  = ir[3 +: RA_W];
  assign fn = ir[2:0];

  function automatic logic [SEL_W-1:0] enc(input logic [RA_W-1:0] idx);
    if (ONEHOT != 0)
      return SEL_W'(1) << idx;
    else
      return SEL_W'(idx);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.run)
        ir <= bus.instr_in;
      if (done_c)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ext_c    = 1'b0;
    ir_in_c  = 1'b0;
    enw_c    = 1'b0;
    enr_c    = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    gout_c   = 1'b0;
    imm_oe_c = 1'b0;
    done_c   = 1'b0;
    alu_c    = 3'b000;
    rin_idx  = '0;
    rout_idx = '0;

    unique case (state)
      IDLE: begin
        if (bus.run) begin
          ext_c   = 1'b1;
          ir_in_c = 1'b1;
        end
      end
      T1: begin
        if (f) begin
          rout_idx = x;
          enr_c    = 1'b1;
          ain_c    = 1'b1;
        end else begin
          case (fn)
            3'b000: begin
              ext_c   = 1'b1;
              rin_idx = x;
              enw_c   = 1'b1;
              done_c  = 1'b1;
            end
            3'b001: begin
              rout_idx = y;
              rin_idx  = x;
              enr_c    = 1'b1;
              enw_c    = 1'b1;
              done_c   = 1'b1;
            end
            3'b100: begin
              rout_idx = y;
              enr_c    = 1'b1;
              gin_c    = 1'b1;
              alu_c    = 3'b100;
            end
            default: begin
              rout_idx = x;
              enr_c    = 1'b1;
              ain_c    = 1'b1;
            end
          endcase
        end
      end
      T2: begin
        if (f) begin
          gin_c    = 1'b1;
          imm_oe_c = 1'b1;
          alu_c    = 3'b010;
        end else if (fn == 3'b100) begin
          gout_c  = 1'b1;
          rin_idx = x;
          enw_c   = 1'b1;
          done_c  = 1'b1;
        end else if (fn != 3'b000 && fn != 3'b001) begin
          rout_idx = y;
          enr_c    = 1'b1;
          gin_c    = 1'b1;
          alu_c    = fn;
        end
      end
      T3: begin
        gout_c  = 1'b1;
        rin_idx = x;
        enw_c   = 1'b1;
        done_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Every done step returns to IDLE; the next fetch happens there, never straight from T3.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.run) state_nx = T1;
      T1:      state_nx = done_c ? IDLE : T2;
      T2:      state_nx = done_c ? IDLE : T3;
      T3:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ext       = ext_c;
  assign bus.ir_in     = ir_in_c;
  assign bus.enw       = enw_c;
  assign bus.enr       = enr_c;
  assign bus.ain       = ain_c;
  assign bus.gin       = gin_c;
  assign bus.gout      = gout_c;
  assign bus.done      = done_c;
  assign bus.alu_op    = alu_c;
  assign bus.imm_oe    = imm_oe_c;
  assign bus.imm       = imm_oe_c ? DATA_W'({y, fn}) : '0;
  assign bus.rin_sel   = enw_c ? enc(rin_idx)  : '0;
  assign bus.rout_sel  = enr_c ? enc(rout_idx) : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.step      = state;
  assign bus.instr_cnt = cnt;
endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: binary, one-hot and narrow-counter instances.
module tb_seq_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_if #(.RA_W(3), .DATA_W(10), .ONEHOT(0), .CNT_W(8)) bus0 ();
  seq_if #(.RA_W(3), .DATA_W(10), .ONEHOT(1), .CNT_W(8)) bus1 ();
  seq_if #(.RA_W(3), .DATA_W(10), .ONEHOT(0), .CNT_W(2)) bus2 ();

  seq_controller #(.RA_W(3), .DATA_W(10), .ONEHOT(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  seq_controller #(.RA_W(3), .DATA_W(10), .ONEHOT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  seq_controller #(.RA_W(3), .DATA_W(10), .ONEHOT(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  localparam logic [9:0] EXT   = 10'h200;
  localparam logic [9:0] IRIN  = 10'h100;
  localparam logic [9:0] ENW   = 10'h080;
  localparam logic [9:0] ENR   = 10'h040;
  localparam logic [9:0] AIN   = 10'h020;
  localparam logic [9:0] GIN   = 10'h010;
  localparam logic [9:0] GOUT  = 10'h008;
  localparam logic [9:0] IMMOE = 10'h004;
  localparam logic [9:0] DONE  = 10'h002;
  localparam logic [9:0] BUSY  = 10'h001;
  localparam logic [9:0] LOADPAT = 10'b0_111_000_000;

  typedef struct packed {
    logic [9:0] strb;
    logic [1:0] step;
    logic [2:0] alu;
    logic [7:0] rin;
    logic [7:0] rout;
    logic [9:0] imm;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    int    d;
    string tag;
    obs_t  e;
  } sb_t;

  sb_t  sbq[$];
  obs_t obs [3];
  int   n_checks = 0;
  int   n_fail   = 0;

  always_comb begin
    obs[0] = '{strb: {bus0.ext, bus0.ir_in, bus0.enw, bus0.enr, bus0.ain, bus0.gin,
                      bus0.gout, bus0.imm_oe, bus0.done, bus0.busy},
               step: bus0.step, alu: bus0.alu_op, rin: 8'(bus0.rin_sel),
               rout: 8'(bus0.rout_sel), imm: bus0.imm, cnt: bus0.instr_cnt};
    obs[1] = '{strb: {bus1.ext, bus1.ir_in, bus1.enw, bus1.enr, bus1.ain, bus1.gin,
                      bus1.gout, bus1.imm_oe, bus1.done, bus1.busy},
               step: bus1.step, alu: bus1.alu_op, rin: bus1.rin_sel,
               rout: bus1.rout_sel, imm: bus1.imm, cnt: bus1.instr_cnt};
    obs[2] = '{strb: {bus2.ext, bus2.ir_in, bus2.enw, bus2.enr, bus2.ain, bus2.gin,
                      bus2.gout, bus2.imm_oe, bus2.done, bus2.busy},
               step: bus2.step, alu: bus2.alu_op, rin: 8'(bus2.rin_sel),
               rout: 8'(bus2.rout_sel), imm: bus2.imm, cnt: 8'(bus2.instr_cnt)};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on instance d, push its expected outputs, then pop and compare mid-cycle.
  task automatic cyc(input int d, input logic run, input logic [9:0] instr, input logic rst,
                     input string tag, input logic [9:0] strb, input logic [1:0] step,
                     input logic [2:0] alu, input logic [7:0] rin, input logic [7:0] rout,
                     input logic [9:0] imm, input logic [7:0] cnt);
    sb_t s;
    reset         = rst;
    bus0.run      = (d == 0) ? run : 1'b0;
    bus1.run      = (d == 1) ? run : 1'b0;
    bus2.run      = (d == 2) ? run : 1'b0;
    bus0.instr_in = (d == 0) ? instr : '0;
    bus1.instr_in = (d == 1) ? instr : '0;
    bus2.instr_in = (d == 2) ? instr : '0;
    s.d   = d;
    s.tag = tag;
    s.e   = '{strb: strb, step: step, alu: alu, rin: rin, rout: rout, imm: imm, cnt: cnt};
    sbq.push_back(s);
    @(negedge clk);
    s = sbq.pop_front();
    check_eq({s.tag, ".strobes"}, 32'(obs[s.d].strb), 32'(s.e.strb));
    check_eq({s.tag, ".step"},    32'(obs[s.d].step), 32'(s.e.step));
    check_eq({s.tag, ".alu_op"},  32'(obs[s.d].alu),  32'(s.e.alu));
    check_eq({s.tag, ".rin_sel"}, 32'(obs[s.d].rin),  32'(s.e.rin));
    check_eq({s.tag, ".rout_sel"},32'(obs[s.d].rout), 32'(s.e.rout));
    check_eq({s.tag, ".imm"},     32'(obs[s.d].imm),  32'(s.e.imm));
    check_eq({s.tag, ".cnt"},     32'(obs[s.d].cnt),  32'(s.e.cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] xv, yv;
    logic [9:0] ins;
    reset = 1'b1;
    bus0.run = 1'b0; bus1.run = 1'b0; bus2.run = 1'b0;
    bus0.instr_in = '0; bus1.instr_in = '0; bus2.instr_in = '0;
    repeat (2) @(posedge clk);
    #1;

    cyc(0, 0, '0, 0, "rst0", '0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, '0, 0, "rst1", '0, 0, 0, 0, 0, 0, 0);
    cyc(2, 0, '0, 0, "rst2", '0, 0, 0, 0, 0, 0, 0);

    // ADD R2,R5
    cyc(0, 1, 10'b0_010_101_010, 0, "add_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, "add_t1", ENR|AIN|BUSY, 1, 0, 0, 2, 0, 0);
    cyc(0, 0, '0, 0, "add_t2", ENR|GIN|BUSY, 2, 3'b010, 0, 5, 0, 0);
    cyc(0, 0, '0, 0, "add_t3", GOUT|ENW|DONE|BUSY, 3, 0, 2, 0, 0, 0);
    cyc(0, 0, '0, 0, "add_idle", '0, 0, 0, 0, 0, 0, 1);

    // LOAD R7
    cyc(0, 1, LOADPAT, 0, "load_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, "load_t1", EXT|ENW|DONE|BUSY, 1, 0, 7, 0, 0, 1);
    cyc(0, 0, '0, 0, "load_idle", '0, 0, 0, 0, 0, 0, 2);

    // ADDI R3,#46
    cyc(0, 1, 10'b1_011_101_110, 0, "addi_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, '0, 0, "addi_t1", ENR|AIN|BUSY, 1, 0, 0, 3, 0, 2);
    cyc(0, 0, '0, 0, "addi_t2", GIN|IMMOE|BUSY, 2, 3'b010, 0, 0, 10'h02E, 2);
    cyc(0, 0, '0, 0, "addi_t3", GOUT|ENW|DONE|BUSY, 3, 0, 3, 0, 0, 2);
    cyc(0, 0, '0, 0, "addi_idle", '0, 0, 0, 0, 0, 0, 3);

    // SUB R4,R1 aborted by reset during T2
    cyc(0, 1, 10'b0_100_001_011, 0, "sub_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 3);
    cyc(0, 0, '0, 0, "sub_t1", ENR|AIN|BUSY, 1, 0, 0, 4, 0, 3);
    cyc(0, 0, '0, 1, "sub_t2", ENR|GIN|BUSY, 2, 3'b011, 0, 1, 0, 3);
    cyc(0, 0, '0, 0, "sub_abort", '0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, "sub_nodone", '0, 0, 0, 0, 0, 0, 0);

    // One-hot COPY R1<-R6
    cyc(1, 1, 10'b0_001_110_001, 0, "copy_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, '0, 0, "copy_t1", ENR|ENW|DONE|BUSY, 1, 0, 8'b0000_0010, 8'b0100_0000, 0, 0);
    cyc(1, 0, '0, 0, "copy_idle", '0, 0, 0, 0, 0, 0, 1);

    // Back-to-back INV with run held high; instr_in changes while busy must be ignored
    for (int i = 0; i < 4; i++) begin
      xv  = 3'(i + 1);
      yv  = 3'(6 - i);
      ins = {1'b0, xv, yv, 3'b100};
      cyc(2, 1, ins, 0, "inv_fetch", EXT|IRIN, 0, 0, 0, 0, 0, 8'(i));
      cyc(2, 1, LOADPAT, 0, "inv_t1", ENR|GIN|BUSY, 1, 3'b100, 0, 8'(yv), 0, 8'(i));
      cyc(2, 1, LOADPAT, 0, "inv_t2", GOUT|ENW|DONE|BUSY, 2, 0, 8'(xv), 0, 0, 8'(i));
    end
    cyc(2, 0, '0, 0, "inv_wrap", '0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
